// File: rtl/ntt_sched_pkg.sv
// Shared types for the NTT/INTT job scheduler: FSM state encoding
// and the job mode encoding used on req_mode/owner_mode.
package ntt_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } sched_state_e;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or after
// ptr, wrapping. Ports: req, ptr in; grant_idx, grant_any out.
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int REQ_IDX_W = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [REQ_IDX_W-1:0] ptr,
    output logic [REQ_IDX_W-1:0] grant_idx,
    output logic                 grant_any
);

    int                   j;
    logic [REQ_IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest
    // requester at/after ptr is the last (winning) write.
    always_comb begin
        grant_idx = '0;
        grant_any = |req;
        j         = 0;
        idx       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j   = (int'(ptr) + i) % NUM_REQ;
            idx = REQ_IDX_W'(j);
            if (req[idx]) begin
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/ntt_job_sched.sv
// Round-robin scheduler sharing one NTT and one INTT core between
// NUM_REQ requesters; owns the bank mux from START through DRAIN.
// Ports: clk, rst (sync, active high); req_valid/req_mode in,
// req_ack/rsp_done/rsp_err out; ntt/intt start out, done in;
// owner_valid/owner_idx/owner_mode drive the bank and core muxes;
// busy = not idle. All outputs are registered.
// Optional build macro NTT_SCHED_WDOG_EN adds a RUN watchdog that
// aborts a job after WDOG_LIMIT cycles with rsp_err.
module ntt_job_sched
    import ntt_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int REQ_IDX_W  = 2,
    parameter int DRAIN_CYC  = 2,
    parameter int WDOG_W     = 16,
    parameter int WDOG_LIMIT = 8192
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_mode,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   rsp_done,
    output logic [NUM_REQ-1:0]   rsp_err,
    output logic                 ntt_start,
    output logic                 intt_start,
    input  logic                 ntt_done,
    input  logic                 intt_done,
    output logic                 owner_valid,
    output logic [REQ_IDX_W-1:0] owner_idx,
    output logic                 owner_mode,
    output logic                 busy
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    sched_state_e         state_q;
    sched_state_e         state_d;
    logic [REQ_IDX_W-1:0] rr_ptr;
    logic [REQ_IDX_W-1:0] grant_idx;
    logic                 grant_any;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 owner_done;
    logic                 wdog_exp;
    logic                 wdog_hit;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .REQ_IDX_W (REQ_IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Only the done of the core this job was started on counts.
    assign owner_done = (owner_mode == MODE_NTT) ? ntt_done : intt_done;

`ifdef NTT_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;

    assign wdog_exp = (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (state_d == S_RUN && state_q != S_RUN) begin
            wdog_cnt <= '0;
        end else if (state_q == S_RUN) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_wdog;

    assign wdog_exp    = 1'b0;
    assign unused_wdog = 32'(WDOG_W) ^ 32'(WDOG_LIMIT);
`endif

    always_comb begin
        state_d  = state_q;
        wdog_hit = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // A done coinciding with expiry takes the normal path.
                if (owner_done) begin
                    state_d = S_DRAIN;
                end else if (wdog_exp) begin
                    state_d  = S_RESP;
                    wdog_hit = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr      <= '0;
            drain_cnt   <= '0;
            req_ack     <= '0;
            rsp_done    <= '0;
            rsp_err     <= '0;
            ntt_start   <= 1'b0;
            intt_start  <= 1'b0;
            owner_valid <= 1'b0;
            owner_idx   <= '0;
            owner_mode  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ack     <= '0;
            rsp_done    <= '0;
            rsp_err     <= '0;
            ntt_start   <= 1'b0;
            intt_start  <= 1'b0;
            busy        <= (state_d != S_IDLE);
            owner_valid <= (state_d == S_START) ||
                           (state_d == S_RUN)   ||
                           (state_d == S_DRAIN);

            if (state_q == S_IDLE && grant_any) begin
                owner_idx  <= grant_idx;
                owner_mode <= req_mode[grant_idx];
                req_ack    <= NUM_REQ'(1) << grant_idx;
            end

            if (state_q == S_START) begin
                ntt_start  <= (owner_mode == MODE_NTT);
                intt_start <= (owner_mode == MODE_INTT);
            end

            // Hold the bank for the last BRAM write-back after done.
            if (state_q == S_RUN && owner_done) begin
                drain_cnt <= DRAIN_W'(DRAIN_CYC - 1);
            end else if (state_q == S_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            if (state_d == S_RESP) begin
                rsp_done <= NUM_REQ'(1) << owner_idx;
                rsp_err  <= wdog_hit ? (NUM_REQ'(1) << owner_idx) : '0;
            end

            if (state_q == S_RESP) begin
                if (int'(owner_idx) == NUM_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= owner_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ntt_job_sched.sv
// Directed self-checking bench for ntt_job_sched: single job,
// contention, wrong-core done, reset mid-job, drop-on-ack, watchdog.
module tb_ntt_job_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_mode;
    logic [3:0] req_ack;
    logic [3:0] rsp_done;
    logic [3:0] rsp_err;
    logic       ntt_start;
    logic       intt_start;
    logic       ntt_done;
    logic       intt_done;
    logic       owner_valid;
    logic [1:0] owner_idx;
    logic       owner_mode;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int ack_cnt = 0;
    int rsp_cnt = 0;
    int err_cnt = 0;
    int ntt_st_cnt = 0;
    int intt_st_cnt = 0;
    int base;
    int base2;
    int base3;

    ntt_job_sched #(
        .NUM_REQ    (4),
        .REQ_IDX_W  (2),
        .DRAIN_CYC  (2),
        .WDOG_W     (16),
        .WDOG_LIMIT (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_mode    (req_mode),
        .req_ack     (req_ack),
        .rsp_done    (rsp_done),
        .rsp_err     (rsp_err),
        .ntt_start   (ntt_start),
        .intt_start  (intt_start),
        .ntt_done    (ntt_done),
        .intt_done   (intt_done),
        .owner_valid (owner_valid),
        .owner_idx   (owner_idx),
        .owner_mode  (owner_mode),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (|req_ack) ack_cnt++;
        if (|rsp_done) rsp_cnt++;
        if (|rsp_err) err_cnt++;
        if (ntt_start) ntt_st_cnt++;
        if (intt_start) intt_st_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_mode  = '0;
        ntt_done  = 1'b0;
        intt_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] all_out();
        return {13'd0, req_ack, rsp_done, rsp_err, ntt_start, intt_start,
                owner_valid, owner_idx, owner_mode, busy};
    endfunction

    // One full job: wait for ack, apply keep mask to req_valid,
    // check start, pulse the owner core's done after dly cycles,
    // expect rsp_done 3 cycles after done (DRAIN_CYC=2).
    task automatic do_job(input int idx, input logic mode, input int dly,
                          input logic [3:0] keep, input string tag);
        int n;
        n = 0;
        while (req_ack == 4'd0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ack"}, req_ack, 32'd1 << idx);
        chk({tag, "_idx"}, owner_idx, idx);
        req_valid = req_valid & keep;
        tick();
        chk({tag, "_start"}, {ntt_start, intt_start},
            mode ? 32'b01 : 32'b10);
        chk({tag, "_mode"}, owner_mode, mode);
        repeat (dly) tick();
        if (mode) intt_done = 1'b1;
        else ntt_done = 1'b1;
        tick();
        ntt_done  = 1'b0;
        intt_done = 1'b0;
        tick();
        chk({tag, "_early"}, rsp_done, 0);
        tick();
        chk({tag, "_rsp"}, rsp_done, 32'd1 << idx);
        chk({tag, "_err"}, rsp_err, 0);
        chk({tag, "_ov"}, owner_valid, 0);
        tick();
    endtask

    initial begin
        do_reset();
        chk("reset_outs", all_out(), 0);

        // Single INTT job on requester 2.
        base  = intt_st_cnt;
        base2 = ntt_st_cnt;
        req_valid = 4'b0100;
        req_mode  = 4'b0100;
        do_job(2, 1'b1, 50, 4'b0000, "t1");
        chk("t1_busy_end", busy, 0);
        chk("t1_intt_starts", intt_st_cnt - base, 1);
        chk("t1_ntt_starts", ntt_st_cnt - base2, 0);

        // Contention, all held, pointer reset to 0.
        do_reset();
        base  = ack_cnt;
        base2 = rsp_cnt;
        req_valid = 4'b1111;
        req_mode  = 4'b1010;
        do_job(0, 1'b0, 5, 4'b1111, "t2a");
        do_job(1, 1'b1, 5, 4'b1111, "t2b");
        do_job(2, 1'b0, 5, 4'b1111, "t2c");
        do_job(3, 1'b1, 5, 4'b1111, "t2d");
        do_job(0, 1'b0, 5, 4'b0000, "t2e");
        chk("t2_acks", ack_cnt - base, 5);
        chk("t2_rsps", rsp_cnt - base2, 5);

        // Wrong-core done and done in START are ignored.
        base = rsp_cnt;
        req_valid = 4'b0001;
        req_mode  = 4'b0000;
        tick();
        chk("t3_ack", req_ack, 4'b0001);
        req_valid = '0;
        ntt_done  = 1'b1;
        tick();
        chk("t3_start", ntt_start, 1);
        ntt_done  = 1'b0;
        intt_done = 1'b1;
        tick();
        intt_done = 1'b0;
        repeat (4) tick();
        chk("t3_still_run", {owner_valid, busy}, 2'b11);
        chk("t3_no_rsp", rsp_cnt - base, 0);
        ntt_done = 1'b1;
        tick();
        ntt_done = 1'b0;
        repeat (2) tick();
        chk("t3_rsp", rsp_done, 4'b0001);
        tick();

        // Requester 1 drops on ack; 3 next; 1 never re-granted.
        base = ack_cnt;
        req_valid = 4'b1010;
        req_mode  = 4'b0000;
        do_job(1, 1'b0, 5, 4'b1000, "t6a");
        do_job(3, 1'b0, 5, 4'b0000, "t6b");
        repeat (4) tick();
        chk("t6_acks", ack_cnt - base, 2);
        chk("t6_idle", busy, 0);

        // Reset 20 cycles into RUN abandons the job silently.
        base = rsp_cnt;
        req_valid = 4'b0100;
        req_mode  = 4'b0000;
        tick();
        chk("t4_ack", req_ack, 4'b0100);
        req_valid = '0;
        tick();
        repeat (20) tick();
        chk("t4_in_run", owner_valid, 1);
        rst = 1'b1;
        tick();
        chk("t4_outs", all_out(), 0);
        rst      = 1'b0;
        ntt_done = 1'b1;
        tick();
        ntt_done = 1'b0;
        repeat (4) tick();
        chk("t4_no_rsp", rsp_cnt - base, 0);
        chk("t4_idle", busy, 0);
        req_valid = 4'b0010;
        do_job(1, 1'b0, 10, 4'b0000, "t4b");

`ifdef NTT_SCHED_WDOG_EN
        // Watchdog expiry after 100 RUN cycles.
        base3 = err_cnt;
        req_valid = 4'b0001;
        req_mode  = 4'b0000;
        tick();
        chk("t5_ack", req_ack, 4'b0001);
        req_valid = '0;
        tick();
        repeat (99) tick();
        chk("t5_not_yet", rsp_done, 0);
        tick();
        chk("t5_rsp", rsp_done, 4'b0001);
        chk("t5_err", rsp_err, 4'b0001);
        tick();
        chk("t5_err_once", err_cnt - base3, 1);

        // Done on the 100th RUN cycle wins over expiry.
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        repeat (99) tick();
        ntt_done = 1'b1;
        tick();
        ntt_done = 1'b0;
        chk("t5b_no_abort", rsp_done, 0);
        repeat (2) tick();
        chk("t5b_rsp", rsp_done, 4'b0001);
        chk("t5b_err", rsp_err, 0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
